// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage of the 16-bit pipelined processor. It owns the PC
// register and the IF/ID pipeline register. The PC addresses a combinational
// instruction ROM, and the ROM word is captured into IF/ID on the next edge.
// After reset the stage holds for a short boot period. It then runs forever,
// obeying three rules in priority order: a taken branch, then a controller
// stall, then a normal fetch.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-low reset
//   pc_stall       controller PCStall; 1 holds PC and IF/ID
//   branch_taken   resolved branch decision from EX/MEM
//   branch_target  branch destination from EX/MEM (bit 0 is ignored)
//   imem_addr      fetch address to the instruction ROM (the PC register)
//   imem_data      ROM word for imem_addr, valid in the same cycle
//   ifid_instr     IF/ID instruction
//   ifid_opcode    top three bits of ifid_instr, returned to the controller
//   ifid_pc_plus   PC + PC_INC of the instruction held in IF/ID
//   ifid_valid     1 when IF/ID holds a fetched instruction, 0 for a bubble
//   boot_done      1 once the boot hold has finished
//   fetch_count    number of instructions loaded into IF/ID (wraps)
// ----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                     PC_WIDTH    = 16,
  parameter int                     INSTR_WIDTH = 16,
  parameter int                     PC_INC      = 2,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0,
  parameter int                     BOOT_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pc_stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [2:0]             ifid_opcode,
  output logic [PC_WIDTH-1:0]    ifid_pc_plus,
  output logic                   ifid_valid,
  output logic                   boot_done,
  output logic [15:0]            fetch_count
);

  // The boot counter is 4 bits, which covers BOOT_CYCLES up to 15.
  localparam logic [3:0]          BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0] PC_STEP   = PC_WIDTH'(PC_INC);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                   state_reg, state_next;
  logic [3:0]               boot_cnt_reg, boot_cnt_next;
  logic                     boot_done_reg, boot_done_next;
  logic [PC_WIDTH-1:0]      pc_reg, pc_next;
  logic [INSTR_WIDTH-1:0]   instr_reg, instr_next;
  logic [PC_WIDTH-1:0]      pc_plus_reg, pc_plus_next;
  logic                     valid_reg, valid_next;
  logic [15:0]              count_reg, count_next;

  // The PC is always even. A branch target has bit 0 cleared so that a
  // malformed target cannot misalign every later fetch.
  logic [PC_WIDTH-1:0]      target_aligned;
  logic [PC_WIDTH-1:0]      pc_incr;

  assign target_aligned = {branch_target[PC_WIDTH-1:1], 1'b0};
  assign pc_incr        = pc_reg + PC_STEP;   // wraps modulo 2^PC_WIDTH

  // --------------------------------------------------------------------------
  // State register. Reset is asynchronous. A reset asserted mid-run drops
  // whatever branch or stall was in flight, because nothing here remembers
  // one.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_BOOT;
      boot_cnt_reg  <= 4'd0;
      boot_done_reg <= 1'b0;
      pc_reg        <= RESET_PC;
      instr_reg     <= NOP_INSTR;
      pc_plus_reg   <= '0;
      valid_reg     <= 1'b0;
      count_reg     <= 16'd0;
    end else begin
      state_reg     <= state_next;
      boot_cnt_reg  <= boot_cnt_next;
      boot_done_reg <= boot_done_next;
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
      pc_plus_reg   <= pc_plus_next;
      valid_reg     <= valid_next;
      count_reg     <= count_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Every register holds its value unless a rule below
  // changes it.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    boot_cnt_next  = boot_cnt_reg;
    boot_done_next = boot_done_reg;
    pc_next        = pc_reg;
    instr_next     = instr_reg;
    pc_plus_next   = pc_plus_reg;
    valid_next     = valid_reg;
    count_next     = count_reg;

    unique case (state_reg)
      ST_BOOT: begin
        // Fetch is frozen and the controller inputs are ignored. boot_done
        // is set on the same edge that enters RUN, so it reads 1 from the
        // first RUN cycle onward.
        boot_cnt_next = boot_cnt_reg + 4'd1;
        if (boot_cnt_reg == BOOT_LAST) begin
          state_next     = ST_RUN;
          boot_done_next = 1'b1;
        end
      end

      ST_RUN: begin
        if (branch_taken) begin
          // A branch outranks a stall. Otherwise the controller could hold
          // the wrong-path instruction in IF/ID forever.
          pc_next    = target_aligned;
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
        end else if (!pc_stall) begin
          instr_next   = imem_data;
          pc_plus_next = pc_incr;
          valid_next   = 1'b1;
          pc_next      = pc_incr;
          count_next   = count_reg + 16'd1;
        end
        // When pc_stall is 1 (and there is no branch), every register keeps
        // its default hold value.
      end

      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. All of them come from registers except ifid_opcode, which is a
  // plain slice of the IF/ID instruction.
  // --------------------------------------------------------------------------
  assign imem_addr    = pc_reg;
  assign ifid_instr   = instr_reg;
  assign ifid_opcode  = instr_reg[INSTR_WIDTH-1 -: 3];
  assign ifid_pc_plus = pc_plus_reg;
  assign ifid_valid   = valid_reg;
  assign boot_done    = boot_done_reg;
  assign fetch_count  = count_reg;

endmodule
